// File: rtl/data_memory_pkg.sv
// Shared types and constants for the parametrised data memory.
package data_memory_pkg;

    // Init sequencer states: filling the array, or open for accesses.
    typedef enum logic {
        MS_INIT,
        MS_READY
    } mem_state_t;

    // Values for the INIT_MODE parameter.
    localparam int unsigned INIT_ZERO     = 0;
    localparam int unsigned INIT_IDENTITY = 1;

endpackage

// File: rtl/mem_init_seq.sv
// Init sequencer: walks the word address 0..DEPTH-1 once per pass, one word per cycle,
// presenting the fill value for each word. Busy for the whole pass.
module mem_init_seq
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned INIT_MODE = INIT_IDENTITY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_add,
    output logic [DATA_W-1:0] init_wd,
    output logic              busy
);

    // Counter stops here; it never passes the last valid word.
    localparam logic [ADDR_W-1:0] CntLast = ADDR_W'(DEPTH - 1);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next-state: advance through the words, restart on a start pulse in either state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MS_INIT: begin
                if (start) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = MS_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            MS_READY: begin
                if (start) begin
                    state_d = MS_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State register; reset lands in MS_INIT so the array is always filled after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fill value: zero, or the word index truncated/extended to the word width.
    always_comb begin
        init_wd = '0;
        if (INIT_MODE == INIT_IDENTITY) begin
            init_wd = DATA_W'(cnt_q);
        end
    end

    assign busy     = (state_q == MS_INIT);
    assign init_we  = busy;
    assign init_add = cnt_q;

endmodule

// File: rtl/data_memory_param.sv
// Single-port data memory with synchronous read, read-valid strobe, out-of-range error flag
// and a hardware init sequencer that owns the write port while it runs.
module data_memory_param
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned INIT_MODE = INIT_IDENTITY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] M_add,
    input  logic [DATA_W-1:0] M_wd,
    input  logic              M_we,
    input  logic              M_re,
    input  logic              M_init,
    output logic [DATA_W-1:0] M_rd,
    output logic              M_rvalid,
    output logic              M_busy,
    output logic              M_err
);

    logic              init_we;
    logic [ADDR_W-1:0] init_add;
    logic [DATA_W-1:0] init_wd;
    logic              busy;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              arr_we;
    logic [ADDR_W-1:0] arr_add;
    logic [DATA_W-1:0] arr_wd;

    logic              in_range;
    logic              acc_we;
    logic              acc_re;

    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    mem_init_seq #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (M_init),
        .init_we  (init_we),
        .init_add (init_add),
        .init_wd  (init_wd),
        .busy     (busy)
    );

    // Always true when DEPTH is a power of two; only non-power-of-two depths leave a hole.
    assign in_range = (32'(M_add) < DEPTH);

    // User accesses are only taken while the sequencer is idle. An M_init pulse in the
    // ready state does not block the access of that same cycle.
    assign acc_we = M_we & ~busy;
    assign acc_re = M_re & ~busy;

    // Array write port: the sequencer has it while busy, the user otherwise.
    always_comb begin
        arr_we  = 1'b0;
        arr_add = M_add;
        arr_wd  = M_wd;
        if (busy) begin
            arr_we  = init_we;
            arr_add = init_add;
            arr_wd  = init_wd;
        end else begin
            arr_we  = acc_we & in_range;
        end
    end

    // Storage array; contents deliberately not reset, the sequencer refills it.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_add] <= arr_wd;
        end
    end

    // Read/err next-state. With a single address port a same-cycle read and write always
    // hit the same word, so the read returns the write data (write-first).
    always_comb begin
        rd_d     = rd_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        if (acc_re) begin
            rvalid_d = 1'b1;
            if (!in_range) begin
                rd_d = '0;
            end else if (acc_we) begin
                rd_d = M_wd;
            end else begin
                rd_d = mem_q[arr_add];
            end
        end
        if ((acc_we || acc_re) && !in_range) begin
            err_d = 1'b1;
        end
    end

    // Registered read data, valid strobe and error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign M_rd     = rd_q;
    assign M_rvalid = rvalid_q;
    assign M_busy   = busy;
    assign M_err    = err_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: three instances cover the identity-fill 16-word case,
// a 12-word (non-power-of-two) case and a zero-fill case.
module tb_data_memory_param;

    logic clk;
    logic rst_n;

    // Per-instance stimulus; index 0 = 16/identity, 1 = 12/identity, 2 = 16/zero.
    logic       we_s   [3];
    logic       re_s   [3];
    logic [3:0] add_s  [3];
    logic [3:0] wd_s   [3];
    logic       init_s [3];
    logic [3:0] rd_o     [3];
    logic       rvalid_o [3];
    logic       busy_o   [3];
    logic       err_o    [3];

    int n_pass;
    int n_total;

    // Reference model of instance 0, kept as plain arrays and counters.
    int m_mem [16];
    int m_rd;
    int m_rvalid;
    int m_err;
    int m_busy_left;

    typedef struct {
        bit       we;
        bit       re;
        bit [3:0] add;
        bit [3:0] wd;
        bit [3:0] exp_rd;
        bit       exp_rvalid;
    } vec_t;

    vec_t tbl[$];

    data_memory_param #(.DATA_W(4), .DEPTH(16), .INIT_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .M_add(add_s[0]), .M_wd(wd_s[0]), .M_we(we_s[0]),
        .M_re(re_s[0]), .M_init(init_s[0]), .M_rd(rd_o[0]), .M_rvalid(rvalid_o[0]),
        .M_busy(busy_o[0]), .M_err(err_o[0])
    );

    data_memory_param #(.DATA_W(4), .DEPTH(12), .INIT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .M_add(add_s[1]), .M_wd(wd_s[1]), .M_we(we_s[1]),
        .M_re(re_s[1]), .M_init(init_s[1]), .M_rd(rd_o[1]), .M_rvalid(rvalid_o[1]),
        .M_busy(busy_o[1]), .M_err(err_o[1])
    );

    data_memory_param #(.DATA_W(4), .DEPTH(16), .INIT_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .M_add(add_s[2]), .M_wd(wd_s[2]), .M_we(we_s[2]),
        .M_re(re_s[2]), .M_init(init_s[2]), .M_rd(rd_o[2]), .M_rvalid(rvalid_o[2]),
        .M_busy(busy_o[2]), .M_err(err_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_rd        = 0;
        m_rvalid    = 0;
        m_err       = 0;
        m_busy_left = 16;
    endfunction

    // One clock edge of the 16-word identity memory, from its behavioural rules.
    function automatic void model_edge(input bit we, input bit re, input int add, input int wd,
                                       input bit init);
        m_rvalid = 0;
        m_err    = 0;
        if (m_busy_left == 0) begin
            if (we) m_mem[add] = wd;
            if (re) begin
                m_rd     = m_mem[add];
                m_rvalid = 1;
            end
            if (init) m_busy_left = 16;
        end else if (init) begin
            m_busy_left = 16;
        end else begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                for (int i = 0; i < 16; i++) m_mem[i] = i % 16;
            end
        end
    endfunction

    // Drive one cycle on instance sel (others idle), then sample 1 time unit after the edge.
    task automatic step(input int sel, input bit we, input bit re, input logic [3:0] add,
                        input logic [3:0] wd, input bit init);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            we_s[k]   = 1'b0;
            re_s[k]   = 1'b0;
            add_s[k]  = 4'h0;
            wd_s[k]   = 4'h0;
            init_s[k] = 1'b0;
        end
        we_s[sel]   = we;
        re_s[sel]   = re;
        add_s[sel]  = add;
        wd_s[sel]   = wd;
        init_s[sel] = init;
        @(posedge clk);
        if (sel == 0) model_edge(we, re, int'(add), int'(wd), init);
        else          model_edge(1'b0, 1'b0, 0, 0, 1'b0);
        #1;
    endtask

    initial begin
        int n;
        n_pass  = 0;
        n_total = 0;
        for (int k = 0; k < 3; k++) begin
            we_s[k]   = 1'b0;
            re_s[k]   = 1'b0;
            add_s[k]  = 4'h0;
            wd_s[k]   = 4'h0;
            init_s[k] = 1'b0;
        end
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        model_reset();

        // Reset state.
        rst_n = 1'b0;
        #12;
        check("reset_rd", int'(rd_o[0]), 0);
        check("reset_rvalid", int'(rvalid_o[0]), 0);
        check("reset_err", int'(err_o[0]), 0);
        check("reset_busy", int'(busy_o[0]), 1);
        check("reset_busy_b", int'(busy_o[1]), 1);

        // Busy lasts exactly DEPTH edges after release.
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            n++;
            if (!busy_o[0]) break;
        end
        check("init_busy_cycles", n, 16);

        // Table: identity readback, write/read, hold, write-first.
        for (int i = 0; i < 16; i++) begin
            tbl.push_back('{we: 1'b0, re: 1'b1, add: 4'(i), wd: 4'h0, exp_rd: 4'(i),
                            exp_rvalid: 1'b1});
        end
        tbl.push_back('{we: 1'b1, re: 1'b0, add: 4'd5, wd: 4'hA, exp_rd: 4'hF, exp_rvalid: 1'b0});
        tbl.push_back('{we: 1'b0, re: 1'b1, add: 4'd5, wd: 4'h0, exp_rd: 4'hA, exp_rvalid: 1'b1});
        tbl.push_back('{we: 1'b0, re: 1'b0, add: 4'd0, wd: 4'h0, exp_rd: 4'hA, exp_rvalid: 1'b0});
        tbl.push_back('{we: 1'b0, re: 1'b0, add: 4'd3, wd: 4'h6, exp_rd: 4'hA, exp_rvalid: 1'b0});
        tbl.push_back('{we: 1'b1, re: 1'b1, add: 4'd7, wd: 4'h3, exp_rd: 4'h3, exp_rvalid: 1'b1});
        tbl.push_back('{we: 1'b0, re: 1'b1, add: 4'd7, wd: 4'h0, exp_rd: 4'h3, exp_rvalid: 1'b1});
        tbl.push_back('{we: 1'b0, re: 1'b1, add: 4'd3, wd: 4'h0, exp_rd: 4'h3, exp_rvalid: 1'b1});
        foreach (tbl[i]) begin
            step(0, tbl[i].we, tbl[i].re, tbl[i].add, tbl[i].wd, 1'b0);
            check($sformatf("tbl%0d_rd", i), int'(rd_o[0]), int'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_rvalid", i), int'(rvalid_o[0]), int'(tbl[i].exp_rvalid));
            check($sformatf("tbl%0d_err", i), int'(err_o[0]), 0);
        end

        // Randomised traffic on instance 0, including occasional init pulses.
        for (int i = 0; i < 300; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0));
            check($sformatf("rnd%0d_rd", i), int'(rd_o[0]), m_rd);
            check($sformatf("rnd%0d_rvalid", i), int'(rvalid_o[0]), m_rvalid);
            check($sformatf("rnd%0d_err", i), int'(err_o[0]), m_err);
            check($sformatf("rnd%0d_busy", i), int'(busy_o[0]), (m_busy_left > 0) ? 1 : 0);
        end

        // DEPTH=12: out-of-range accesses.
        step(1, 1'b0, 1'b1, 4'd11, 4'h0, 1'b0);
        check("b_read11", int'(rd_o[1]), 11);
        step(1, 1'b1, 1'b0, 4'd13, 4'h5, 1'b0);
        check("b_wr13_err", int'(err_o[1]), 1);
        check("b_wr13_rvalid", int'(rvalid_o[1]), 0);
        step(1, 1'b0, 1'b1, 4'd13, 4'h0, 1'b0);
        check("b_rd13_err", int'(err_o[1]), 1);
        check("b_rd13_rvalid", int'(rvalid_o[1]), 1);
        check("b_rd13_rd", int'(rd_o[1]), 0);
        step(1, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        check("b_err_pulse", int'(err_o[1]), 0);
        step(1, 1'b0, 1'b1, 4'd1, 4'h0, 1'b0);
        check("b_read1", int'(rd_o[1]), 1);
        check("b_read1_err", int'(err_o[1]), 0);

        // Zero-fill re-init via M_init; reads during busy are ignored.
        step(2, 1'b1, 1'b0, 4'd2, 4'hF, 1'b0);
        step(2, 1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
        check("c_read2_pre", int'(rd_o[2]), 15);
        step(2, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);
        check("c_busy_after_init", int'(busy_o[2]), 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step(2, 1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
            check($sformatf("c_busy_rvalid%0d", i), int'(rvalid_o[2]), 0);
            check($sformatf("c_busy_rd%0d", i), int'(rd_o[2]), 15);
            if (!busy_o[2]) break;
            n++;
        end
        check("c_busy_cycles", n, 16);
        step(2, 1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
        check("c_read2_post", int'(rd_o[2]), 0);
        check("c_read2_rvalid", int'(rvalid_o[2]), 1);

        // Reset in the middle of an init pass.
        n = 0;
        for (int i = 0; i < 40 && busy_o[0]; i++) begin
            step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            n++;
        end
        check("a_idle_before_reset", int'(busy_o[0]), 0);
        step(0, 1'b1, 1'b0, 4'd3, 4'h9, 1'b0);
        step(0, 1'b0, 1'b1, 4'd3, 4'h0, 1'b0);
        check("a_read3", int'(rd_o[0]), 9);
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("a_midinit_busy", int'(busy_o[0]), 1);
        check("a_midinit_rd_hold", int'(rd_o[0]), 9);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("a_rst_rd", int'(rd_o[0]), 0);
        check("a_rst_busy", int'(busy_o[0]), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            n++;
            if (!busy_o[0]) break;
        end
        check("a_reinit_busy_cycles", n, 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b0, 1'b1, 4'(i), 4'h0, 1'b0);
            check($sformatf("a_reinit_rd%0d", i), int'(rd_o[0]), i);
            check($sformatf("a_reinit_rvalid%0d", i), int'(rvalid_o[0]), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
